// File: rtl/mux_rr_arbiter_if.sv
// Bundle of requester, consumer and arbitration status signals for mux_rr_arbiter.
// The arbiter takes the slave view; the producers/consumer side takes master.
interface mux_rr_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             in0_valid;
    logic [WIDTH-1:0] in0_data;
    logic             in0_last;
    logic             in0_ready;

    logic             in1_valid;
    logic [WIDTH-1:0] in1_data;
    logic             in1_last;
    logic             in1_ready;

    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_ready;

    logic             sel;
    logic [1:0]       gnt;
    logic             busy;

    modport master (
        output in0_valid, in0_data, in0_last,
        output in1_valid, in1_data, in1_last,
        output out_ready,
        input  in0_ready, in1_ready,
        input  out_valid, out_data, out_src,
        input  sel, gnt, busy
    );

    modport slave (
        input  in0_valid, in0_data, in0_last,
        input  in1_valid, in1_data, in1_last,
        input  out_ready,
        output in0_ready, in1_ready,
        output out_valid, out_data, out_src,
        output sel, gnt, busy
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin burst arbiter driving a shared 2:1 datapath into a one-entry output stage.
// Optional stall release on the granted port is enabled by defining ARB_TIMEOUT_EN.
module mux_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 8
) (
    input logic             clk,
    input logic             rst_n,
    mux_rr_arbiter_if.slave bus
);
    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    if (MAX_BURST < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("mux_rr_arbiter: MAX_BURST and TIMEOUT must be >= 1");
    end

    state_t           state_q, state_d;
    logic             sel_q, sel_d;
    logic             ptr_q, ptr_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [CW-1:0]    beat_q, beat_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_src_q, out_src_d;

    logic             cur_valid;
    logic             cur_last;
    logic [WIDTH-1:0] cur_data;
    logic             can_load;
    logic             grant_rdy;
    logic             xfer;
    logic             at_limit;
    logic             burst_done;
    logic             stall_hit;
    logic             win;

    // The granted port as seen through the 2:1 select stage.
    assign cur_valid = sel_q ? bus.in1_valid : bus.in0_valid;
    assign cur_last  = sel_q ? bus.in1_last  : bus.in0_last;
    assign cur_data  = sel_q ? bus.in1_data  : bus.in0_data;

    // A new beat may enter when the output slot is empty or drains this cycle.
    assign can_load   = !out_valid_q || bus.out_ready;
    assign grant_rdy  = (state_q == BUSY) && can_load;
    assign xfer       = grant_rdy && cur_valid;
    assign at_limit   = (beat_q == LAST_BEAT);
    assign burst_done = xfer && (cur_last || at_limit);

    // Tie-break between simultaneous requests uses the round-robin pointer.
    assign win = (bus.in0_valid && bus.in1_valid) ? ptr_q : bus.in1_valid;

`ifdef ARB_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);

    logic [SW-1:0] stall_q, stall_d;

    // Count idle cycles of the granted port; the TIMEOUT-th one forces release.
    always_comb begin
        stall_d   = stall_q;
        stall_hit = 1'b0;
        if (state_q != BUSY || xfer) begin
            stall_d = '0;
        end else if (!cur_valid) begin
            if (stall_q == SW'(TIMEOUT - 1)) begin
                stall_hit = 1'b1;
                stall_d   = '0;
            end else begin
                stall_d = stall_q + 1'b1;
            end
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`else
    assign stall_hit = 1'b0;
`endif

    // Arbitration FSM: pick a winner in IDLE, hold the grant in BUSY until release.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        beat_d  = beat_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in0_valid || bus.in1_valid) begin
                    sel_d   = win;
                    gnt_d   = win ? 2'b10 : 2'b01;
                    beat_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (xfer) begin
                    beat_d = beat_q + 1'b1;
                end
                if (burst_done || stall_hit) begin
                    state_d = IDLE;
                    ptr_d   = ~sel_q;
                    gnt_d   = 2'b00;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arbitration state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            ptr_q   <= 1'b0;
            gnt_q   <= 2'b00;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            beat_q  <= beat_d;
        end
    end

    // Output slot: load on transfer, otherwise empty once the consumer takes it.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = cur_data;
            out_src_d   = sel_q;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output slot register; reset drops any beat not yet consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign bus.in0_ready = grant_rdy && !sel_q;
    assign bus.in1_ready = grant_rdy && sel_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.sel       = sel_q;
    assign bus.gnt       = gnt_q;
    assign bus.busy      = (state_q == BUSY);
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: per-cycle vector table for control outputs,
// plus a beat scoreboard for out_data/out_src ordering.
module tb_mux_rr_arbiter;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mux_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mux_rr_arbiter #(
        .WIDTH(WIDTH),
        .MAX_BURST(4),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        logic       rs;
        logic       v0;
        logic [7:0] d0;
        logic       l0;
        logic       v1;
        logic [7:0] d1;
        logic       l1;
        logic       ordy;
        logic       er0;
        logic       er1;
        logic [1:0] eg;
        logic       eb;
        logic       es;
        logic       eov;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       src;
    } beat_t;

    vec_t  vecs[$];
    beat_t sb[$];
    int    errors = 0;
    int    checks = 0;
    vec_t  v;
    beat_t b;

    function automatic void r(
        input logic rs, input logic v0, input logic [7:0] d0, input logic l0,
        input logic v1, input logic [7:0] d1, input logic l1, input logic ordy,
        input logic er0, input logic er1, input logic [1:0] eg,
        input logic eb, input logic es, input logic eov
    );
        vec_t t;
        t.rs = rs;   t.v0 = v0;   t.d0 = d0; t.l0 = l0;
        t.v1 = v1;   t.d1 = d1;   t.l1 = l1; t.ordy = ordy;
        t.er0 = er0; t.er1 = er1; t.eg = eg;
        t.eb = eb;   t.es = es;   t.eov = eov;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in0_valid = 1'b0;
        bus.in0_data  = '0;
        bus.in0_last  = 1'b0;
        bus.in1_valid = 1'b0;
        bus.in1_data  = '0;
        bus.in1_last  = 1'b0;
        bus.out_ready = 1'b0;

        // single beat on port 0, then port 1 wins a tie via ptr=1
        r(1, 1,'hA1,1, 0,0,0, 1,  0,0,0,0,0,0);
        r(1, 1,'hA1,1, 0,0,0, 1,  1,0,1,1,0,0);
        r(1, 0,0,0,    0,0,0, 1,  0,0,0,0,0,1);
        r(1, 0,0,0,    0,0,0, 1,  0,0,0,0,0,0);
        r(1, 1,'hB0,1, 1,'hB1,1, 1,  0,0,0,0,0,0);
        r(1, 1,'hB0,1, 1,'hB1,1, 1,  0,1,2,1,1,0);
        r(0, 0,0,0,    0,0,0, 1,  0,0,0,0,1,1);
        // both requesting two-beat bursts: 0, 1, 0 with bubbles
        r(1, 1,'h10,0, 1,'h20,0, 1,  0,0,0,0,0,0);
        r(1, 1,'h10,0, 1,'h20,0, 1,  1,0,1,1,0,0);
        r(1, 1,'h11,1, 1,'h20,0, 1,  1,0,1,1,0,1);
        r(1, 1,'h12,0, 1,'h20,0, 1,  0,0,0,0,0,1);
        r(1, 1,'h12,0, 1,'h20,0, 1,  0,1,2,1,1,0);
        r(1, 1,'h12,0, 1,'h21,1, 1,  0,1,2,1,1,1);
        r(1, 1,'h12,0, 0,0,0,    1,  0,0,0,0,1,1);
        r(1, 1,'h12,0, 0,0,0,    1,  1,0,1,1,0,0);
        r(1, 1,'h13,1, 0,0,0,    1,  1,0,1,1,0,1);
        r(1, 0,0,0,    0,0,0,    1,  0,0,0,0,0,1);
        // port 1 never signals last: forced release after 4 beats
        r(1, 1,'h40,0, 1,'h30,0, 1,  0,0,0,0,0,0);
        r(1, 1,'h40,0, 1,'h30,0, 1,  0,1,2,1,1,0);
        r(1, 1,'h40,0, 1,'h31,0, 1,  0,1,2,1,1,1);
        r(1, 1,'h40,0, 1,'h32,0, 1,  0,1,2,1,1,1);
        r(1, 1,'h40,0, 1,'h33,0, 1,  0,1,2,1,1,1);
        r(1, 1,'h40,0, 1,'h34,0, 1,  0,0,0,0,1,1);
        r(1, 1,'h40,1, 1,'h34,0, 1,  1,0,1,1,0,0);
        r(1, 0,0,0,    0,0,0,    1,  0,0,0,0,0,1);
        // consumer back-pressure for 3 cycles
        r(1, 1,'h50,0, 0,0,0, 1,  0,0,0,0,0,0);
        r(1, 1,'h50,0, 0,0,0, 1,  1,0,1,1,0,0);
        for (int k = 0; k < 3; k++)
            r(1, 1,'h51,0, 0,0,0, 0,  0,0,1,1,0,1);
        r(1, 1,'h51,0, 0,0,0, 1,  1,0,1,1,0,1);
        r(1, 1,'h52,1, 0,0,0, 1,  1,0,1,1,0,1);
        r(1, 0,0,0,    0,0,0, 1,  0,0,0,0,0,1);
        r(1, 0,0,0,    0,0,0, 1,  0,0,0,0,0,0);
        // reset in the middle of a 3-beat burst on port 1
        r(1, 0,0,0, 1,'h60,0, 1,  0,0,0,0,0,0);
        r(1, 0,0,0, 1,'h60,0, 1,  0,1,2,1,1,0);
        r(1, 0,0,0, 1,'h61,0, 1,  0,1,2,1,1,1);
        r(0, 0,0,0, 1,'h62,1, 0,  0,0,2,1,1,1);
        r(1, 1,'h70,1, 1,'h62,1, 1,  0,0,0,0,0,0);
        r(1, 1,'h70,1, 1,'h62,1, 1,  1,0,1,1,0,0);
        r(1, 0,0,0,    1,'h62,1, 1,  0,0,0,0,0,1);
        r(1, 0,0,0,    1,'h62,1, 1,  0,1,2,1,1,0);
        r(1, 0,0,0,    0,0,0,    1,  0,0,0,0,1,1);
        r(1, 0,0,0,    0,0,0,    1,  0,0,0,0,1,0);
        // granted port 0 stops after one beat while port 1 waits
        r(1, 1,'h80,0, 1,'h90,1, 1,  0,0,0,0,1,0);
        r(1, 1,'h80,0, 1,'h90,1, 1,  1,0,1,1,0,0);
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k <= 8; k++)
            r(1, 0,0,0, 1,'h90,1, 1,  1,0,1,1,0,(k == 1));
        r(1, 0,0,0, 1,'h90,1, 1,  0,0,0,0,0,0);
        r(1, 0,0,0, 1,'h90,1, 1,  0,1,2,1,1,0);
        r(1, 0,0,0, 0,0,0,    1,  0,0,0,0,1,1);
        r(1, 0,0,0, 0,0,0,    1,  0,0,0,0,1,0);
`else
        for (int k = 1; k <= 20; k++)
            r(1, 0,0,0, 1,'h90,1, 1,  1,0,1,1,0,(k == 1));
        r(1, 1,'h81,1, 1,'h90,1, 1,  1,0,1,1,0,0);
        r(1, 0,0,0,    1,'h90,1, 1,  0,0,0,0,0,1);
        r(1, 0,0,0,    1,'h90,1, 1,  0,1,2,1,1,0);
        r(1, 0,0,0,    0,0,0,    1,  0,0,0,0,1,1);
        r(1, 0,0,0,    0,0,0,    1,  0,0,0,0,1,0);
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in0_ready", -1, bus.in0_ready, 0);
        chk("rst_in1_ready", -1, bus.in1_ready, 0);
        chk("rst_out_valid", -1, bus.out_valid, 0);
        chk("rst_out_data",  -1, bus.out_data, 0);
        chk("rst_out_src",   -1, bus.out_src, 0);
        chk("rst_gnt",       -1, bus.gnt, 0);
        chk("rst_busy",      -1, bus.busy, 0);
        chk("rst_sel",       -1, bus.sel, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(posedge clk);
            #1;
            rst_n         = v.rs;
            bus.in0_valid = v.v0;
            bus.in0_data  = v.d0;
            bus.in0_last  = v.l0;
            bus.in1_valid = v.v1;
            bus.in1_data  = v.d1;
            bus.in1_last  = v.l1;
            bus.out_ready = v.ordy;
            @(negedge clk);
            chk("in0_ready", i, bus.in0_ready, v.er0);
            chk("in1_ready", i, bus.in1_ready, v.er1);
            chk("gnt",       i, bus.gnt, v.eg);
            chk("busy",      i, bus.busy, v.eb);
            chk("sel",       i, bus.sel, v.es);
            chk("out_valid", i, bus.out_valid, v.eov);
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat row %0d: got data %0h, want no beat",
                             i, bus.out_data);
                end else begin
                    b = sb.pop_front();
                    chk("out_data", i, bus.out_data, b.data);
                    chk("out_src",  i, bus.out_src, b.src);
                end
            end
            if (!v.rs) begin
                sb.delete();
            end else begin
                if (v.er0 && v.v0) sb.push_back('{v.d0, 1'b0});
                if (v.er1 && v.v1) sb.push_back('{v.d1, 1'b1});
            end
        end

        chk("sb_drained", vecs.size(), sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
